spike_odometry_encoder: RTL
===========================

// Module: spike_odometry_encoder
// PURPOSE
//  Upstream front-end of the neuromorphic dead-reckoning integrator. Four spike channels (E/N/W/S)
//  each feed a leaky integrate-and-fire (LIF) neuron. A firing neuron is round-robin arbitrated
//  into a 4-deep move FIFO. The FIFO head is offered to the integrator as a valid/ready move word
//  {14'b0, dir[1:0], step[15:0]}, the same layout the integrator's sensor register decodes.
// PARAMETERS
//  MEM_W       8   membrane width, unsigned, saturating
//  LEAK_PERIOD 16  cycles between leak ticks (>=2); each tick decrements every nonzero membrane by 1
//  FIFO_DEPTH  4   move FIFO entries (power of 2)
//  STEP_W      16  step magnitude width
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       reset, asynchronous, active-low
//  spike_in     in   4       raw pin spikes, async; [0]=E [1]=N [2]=W [3]=S
//  cfg_enable   in   1       0: membranes forced to 0, no new grants; FIFO still drains
//  cfg_clear    in   1       sync pulse: flush membranes, FIFO, rr pointer, sat_sticky
//  cfg_thresh   in   MEM_W   fire threshold; a value of 0 is treated as 1
//  cfg_weight   in   4       membrane increment per spike
//  cfg_step     in   STEP_W  magnitude written into each move word, sampled at push
//  mv_valid     out  1       FIFO not empty
//  mv_ready     in   1       downstream accepts head
//  mv_data      out  32      FIFO head {14'b0, dir, step}
//  fifo_level   out  3       occupancy 0..4
//  sat_sticky   out  1       some membrane hit 2^MEM_W-1 while its fire was blocked
// BEHAVIOUR
//  Reset: all membranes, rr pointer, leak counter, FIFO pointers and sat_sticky are 0.
//   mv_valid=0, mv_data=0, fifo_level=0.
//  Input path: per channel 2-FF synchronizer, then rising-edge detect (spk = s2 & ~s3).
//   A pin edge produces one spk pulse 3 cycles later. A held level produces one pulse only.
//  Leak counter: free-running 0..LEAK_PERIOD-1. leak_tick asserts when the count is LEAK_PERIOD-1.
//  Membrane update per channel, in priority order:
//   1) granted this cycle: mem <= spk ? weight : 0
//   2) otherwise: mem <= sat(mem + (spk?weight:0) - (leak_tick && sum>0 ? 1 : 0))
//      Spike and leak in the same cycle net to +weight-1.
//   Saturation clamps at 2^MEM_W-1.
//  Request: req[i] = cfg_enable && (mem[i] >= max(cfg_thresh,1)), taken from the registered membrane.
//  Arbiter: round-robin starting at rr_ptr. At most one grant per cycle, and only if FIFO not full.
//   On grant, rr_ptr <= grant_idx+1 (mod 4).
//   Push-when-full is blocked even if a pop occurs that cycle (no bypass).
//   Blocked requests stay pending; no event is lost.
//   sat_sticky sets if req[i] && blocked && mem[i]==max. Cleared only by reset or cfg_clear.
//  Move word pushed on grant: dir=grant_idx (0 E, 1 N, 2 W, 3 S), step=cfg_step.
//   Grant in cycle T gives mv_valid in T+1.
//  FIFO: pop when mv_valid&&mv_ready. Simultaneous push+pop (not full) keeps the level.
//   mv_data is stable while mv_valid && !mv_ready. When empty, mv_data=0.
//  cfg_enable=0: mem<=0 every cycle, req=0; leak counter keeps running.
//  cfg_clear: takes effect next edge. It overrides same-cycle grant/push/pop and discards pending words.
//  Pointers wrap modulo FIFO_DEPTH. A full FIFO is distinguished from empty by an extra pointer bit.
// STRUCTURE
//  Package neuro_nav_pkg:
//   dir_e enum {DIR_E=0, DIR_N=1, DIR_W=2, DIR_S=3}
//   move_word_t packed struct {pad[13:0], dir_e dir, step[15:0]}
//   MOVE_DIR_LSB=16, MOVE_DIR_MSB=17
//  Sub-module lif_neuron (sync+edge detect+membrane+req), generate x4.
//  Arbiter, leak counter and FIFO stay inline in the top.
// TESTING
//  1 thresh=16,weight=4,step=5,LEAK_PERIOD=1024, 4 edges on [0] -> one mv_data=0x0000_0005,
//    mv_valid 1 cycle after grant; then 4 edges on [1] -> 0x0001_0005.
//  2 All 4 membranes reach threshold same cycle, rr_ptr=0, mv_ready=1 -> words dir 0,1,2,3
//    in consecutive cycles; rr_ptr ends at 0.
//  3 mv_ready=0, 6 fires (mixed ch) -> fifo_level=4, 2 still pending, sat_sticky=0.
//    Release mv_ready -> all 6 words delivered in grant order.
//  4 thresh=16,weight=4,LEAK_PERIOD=16: 3 edges then idle 200 cycles -> membrane decays to 0,
//    no mv_valid. Spike coincident with leak tick -> mem +3.
//  5 mv_ready=0 with FIFO full, weight=15, thresh=8, 20 edges on [2] -> membrane clamps at 255,
//    sat_sticky=1. cfg_clear -> level 0, sticky 0, mv_valid 0.
//  6 rst_n low mid-burst (level=3) -> mv_valid=0, fifo_level=0 asynchronously.
//    After release, a 3-cycle-wide pin pulse yields exactly one spike.

Source files
------------

// File: rtl/neuro_nav_pkg.sv
// Shared types for the neuromorphic navigation front-end: move-word layout and direction codes.
package neuro_nav_pkg;

    localparam int unsigned N_CH         = 4;
    localparam int unsigned STEP_W       = 16;
    localparam int unsigned MOVE_W       = 32;
    localparam int unsigned MOVE_DIR_LSB = 16;
    localparam int unsigned MOVE_DIR_MSB = 17;

    typedef enum logic [1:0] {
        DIR_E = 2'd0,
        DIR_N = 2'd1,
        DIR_W = 2'd2,
        DIR_S = 2'd3
    } dir_e;

    typedef struct packed {
        logic [13:0]       pad;
        dir_e              dir;
        logic [STEP_W-1:0] step;
    } move_word_t;

    // Builds a move word with the layout the integrator's sensor register decodes.
    function automatic move_word_t make_move(input logic [1:0] idx, input logic [STEP_W-1:0] step);
        logic [MOVE_W-1:0] raw;
        raw                            = '0;
        raw[STEP_W-1:0]                = step;
        raw[MOVE_DIR_MSB:MOVE_DIR_LSB] = idx;
        return move_word_t'(raw);
    endfunction

endpackage

// File: rtl/spike_odometry_encoder_if.sv
// Valid/ready move-word channel from the spike encoder to the dead-reckoning integrator.
interface spike_odometry_encoder_if;
    import neuro_nav_pkg::*;

    logic       mv_valid;
    logic       mv_ready;
    move_word_t mv_data;

    modport master (output mv_valid, output mv_data, input mv_ready);
    modport slave  (input mv_valid, input mv_data, output mv_ready);
endinterface

// File: rtl/lif_neuron.sv
// One spike channel: pin synchronizer, rising-edge detect, leaky saturating membrane, fire request.
module lif_neuron #(
    parameter int unsigned MEM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_pin,
    input  logic             enable,
    input  logic             clear,
    input  logic             grant,
    input  logic             leak_tick,
    input  logic [MEM_W-1:0] thresh,
    input  logic [3:0]       weight,
    output logic             req_c,
    output logic             at_max_c
);

    localparam int unsigned SUM_W = MEM_W + 2;
    localparam logic [MEM_W-1:0] MEM_MAX = '1;

    logic             s1, s2, s3;
    logic             spk;
    logic [MEM_W-1:0] mem, mem_nxt, thr_eff;
    logic [SUM_W-1:0] sum, net;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= spike_pin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign spk = s2 & ~s3;

    always_comb begin
        sum = SUM_W'(mem) + (spk ? SUM_W'(weight) : SUM_W'(0));
        net = (leak_tick && (sum != '0)) ? sum - SUM_W'(1) : sum;
        if (clear || !enable) begin
            mem_nxt = '0;
        end else if (grant) begin
            mem_nxt = spk ? MEM_W'(weight) : '0;
        end else if (net > SUM_W'(MEM_MAX)) begin
            mem_nxt = MEM_MAX;
        end else begin
            mem_nxt = net[MEM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem <= '0;
        else        mem <= mem_nxt;
    end

    // A zero threshold would fire on an empty membrane, so it is lifted to 1.
    assign thr_eff  = (thresh == '0) ? MEM_W'(1) : thresh;
    assign req_c    = enable && (mem >= thr_eff);
    assign at_max_c = (mem == MEM_MAX);

endmodule

// File: rtl/spike_odometry_encoder.sv
// Four LIF spike channels, round-robin arbitrated into a small move FIFO offered over valid/ready.
module spike_odometry_encoder
    import neuro_nav_pkg::*;
#(
    parameter int unsigned MEM_W       = 8,
    parameter int unsigned LEAK_PERIOD = 16,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CH-1:0]                spike_in,
    input  logic                           cfg_enable,
    input  logic                           cfg_clear,
    input  logic [MEM_W-1:0]               cfg_thresh,
    input  logic [3:0]                     cfg_weight,
    input  logic [STEP_W-1:0]              cfg_step,
    spike_odometry_encoder_if.master       mv,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           sat_sticky
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PW     = PTR_W + 1;
    localparam int unsigned LEAK_W = $clog2(LEAK_PERIOD);

    logic [LEAK_W-1:0] leak_cnt;
    logic              leak_tick;
    logic [N_CH-1:0]   req, at_max, gnt;
    logic [1:0]        rr_ptr, gnt_idx, cand;
    logic              gnt_any;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              empty, full, push, pop;
    move_word_t        fifo_mem [FIFO_DEPTH];

    assign leak_tick = (leak_cnt == LEAK_W'(LEAK_PERIOD - 1));

    // Free-running leak timebase; unaffected by cfg_clear or cfg_enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         leak_cnt <= '0;
        else if (leak_tick) leak_cnt <= '0;
        else                leak_cnt <= leak_cnt + LEAK_W'(1);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        lif_neuron #(.MEM_W(MEM_W)) u_lif (
            .clk       (clk),
            .rst_n     (rst_n),
            .spike_pin (spike_in[i]),
            .enable    (cfg_enable),
            .clear     (cfg_clear),
            .grant     (gnt[i]),
            .leak_tick (leak_tick),
            .thresh    (cfg_thresh),
            .weight    (cfg_weight),
            .req_c     (req[i]),
            .at_max_c  (at_max[i])
        );
    end

    // Round-robin search from rr_ptr; no grant while full (no pop bypass) or clearing.
    always_comb begin
        gnt     = '0;
        gnt_idx = rr_ptr;
        gnt_any = 1'b0;
        cand    = rr_ptr;
        if (!full && !cfg_clear) begin
            for (int k = 0; k < N_CH; k++) begin
                cand = rr_ptr + 2'(k);
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            gnt[gnt_idx] = gnt_any;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push  = gnt_any;
    assign pop   = !empty && mv.mv_ready && !cfg_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rr_ptr     <= '0;
            sat_sticky <= 1'b0;
        end else if (cfg_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rr_ptr     <= '0;
            sat_sticky <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                rr_ptr <= gnt_idx + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (|(req & ~gnt & at_max)) sat_sticky <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= make_move(gnt_idx, cfg_step);
    end

    assign mv.mv_valid = !empty;
    assign mv.mv_data  = empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
    assign fifo_level  = wr_ptr - rd_ptr;

endmodule
